serial_add_ctrl: RTL and testbench

//  Bit-serial adder controller: the sequential stage that drives the one-bit

---
 rtl/serial_add_ctrl.sv | 99 +++++++++
 tb/tb_serial_add_ctrl.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: shifts two operands LSB-first through a single
// full-adder cell, recirculating the carry through a flop, with start/done handshake.
module serial_add_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum_out,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned CntW = $clog2(WIDTH);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  a_sr_q, b_sr_q, res_sr_q;
  logic [WIDTH-1:0]  res_next;
  logic              carry_q;
  logic [CntW-1:0]   cnt_q;
  logic              fa_s, fa_co;
  logic              last_bit;

  // The single full-adder cell.
  assign fa_s     = a_sr_q[0] ^ b_sr_q[0] ^ carry_q;
  assign fa_co    = (a_sr_q[0] & b_sr_q[0]) | (carry_q & (a_sr_q[0] ^ b_sr_q[0]));
  assign res_next = {fa_s, res_sr_q[WIDTH-1:1]};
  assign last_bit = (cnt_q == CntW'(WIDTH - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StShift;
      StShift: if (last_bit) state_d = StDone;
      StDone:  state_d = start ? StShift : StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    busy = (state_q == StShift);
    done = (state_q == StDone);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      res_sr_q <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      sum_out  <= '0;
      cout     <= 1'b0;
      ovf      <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          if (start) begin
            a_sr_q  <= a_in;
            b_sr_q  <= b_in;
            carry_q <= cin;
            cnt_q   <= '0;
          end
        end
        StShift: begin
          res_sr_q <= res_next;
          a_sr_q   <= a_sr_q >> 1;
          b_sr_q   <= b_sr_q >> 1;
          carry_q  <= fa_co;
          if (last_bit) begin
            // carry_q here is the carry into the MSB.
            sum_out <= res_next;
            cout    <= fa_co;
            ovf     <= carry_q ^ fa_co;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed self-checking bench for serial_add_ctrl (WIDTH=8): latency, back-to-back
// starts, ignored start while busy, asynchronous reset mid-operation.
module tb_serial_add_ctrl;

  localparam int unsigned W = 8;

  logic         clk, rst, start, cin;
  logic [W-1:0] a_in, b_in;
  logic         busy, done, cout, ovf;
  logic [W-1:0] sum_out;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .a_in    (a_in),
    .b_in    (b_in),
    .cin     (cin),
    .busy    (busy),
    .done    (done),
    .sum_out (sum_out),
    .cout    (cout),
    .ovf     (ovf)
  );

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic       c;
    logic [7:0] s;
    logic       co;
    logic       ov;
  } vec_t;

  vec_t vecs [11];

  int n_vec   = 0;
  int n_err   = 0;
  int n_start = 0;
  int done_cnt = 0;
  int overlap  = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (done) done_cnt++;
    if (busy && done) overlap++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; start is seen by the following posedge.
  task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic c);
    a_in  = a;
    b_in  = b;
    cin   = c;
    start = 1'b1;
    n_start++;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int start_k, output int lat);
    lat = start_k;
    do begin
      @(negedge clk);
      lat++;
    end while (!done && lat < 40);
  endtask

  initial begin
    int lat;
    int d0;

    vecs[0]  = '{8'h3C, 8'h55, 1'b0, 8'h91, 1'b0, 1'b1};
    vecs[1]  = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[2]  = '{8'h7F, 8'h00, 1'b1, 8'h80, 1'b0, 1'b1};
    vecs[3]  = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
    vecs[4]  = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
    vecs[5]  = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[6]  = '{8'hAA, 8'h55, 1'b1, 8'h00, 1'b1, 1'b0};
    vecs[7]  = '{8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0};
    vecs[8]  = '{8'hC0, 8'hA0, 1'b0, 8'h60, 1'b1, 1'b1};
    vecs[9]  = '{8'h5A, 8'h5A, 1'b1, 8'hB5, 1'b0, 1'b1};
    vecs[10] = '{8'h01, 8'h7E, 1'b0, 8'h7F, 1'b0, 1'b0};

    rst = 1'b1; start = 1'b0; a_in = '0; b_in = '0; cin = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_sum", sum_out, 0);
    check("rst_cout", cout, 0);
    check("rst_ovf", ovf, 0);
    rst = 1'b0;
    @(negedge clk);

    // Whole table back-to-back: each next start is issued in the DONE cycle.
    issue(vecs[0].a, vecs[0].b, vecs[0].c);
    for (int i = 0; i < 11; i++) begin
      check($sformatf("busy_v%0d", i), busy, 1);
      if (i > 0) check($sformatf("hold_v%0d", i), sum_out, vecs[i-1].s);
      wait_done(0, lat);
      check($sformatf("lat_v%0d", i), lat, W);
      check($sformatf("sum_v%0d", i), sum_out, vecs[i].s);
      check($sformatf("cout_v%0d", i), cout, vecs[i].co);
      check($sformatf("ovf_v%0d", i), ovf, vecs[i].ov);
      if (i < 10) issue(vecs[i+1].a, vecs[i+1].b, vecs[i+1].c);
    end
    @(negedge clk);
    check("idle_done", done, 0);
    check("idle_busy", busy, 0);
    check("idle_hold", sum_out, 8'h7F);

    // Start while busy must be ignored.
    d0 = done_cnt;
    issue(8'h10, 8'h20, 1'b0);
    repeat (2) @(negedge clk);
    a_in = 8'hFF; b_in = 8'hFF; cin = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("ign_busy", busy, 1);
    wait_done(3, lat);
    check("ign_lat", lat, W);
    check("ign_sum", sum_out, 8'h30);
    check("ign_cout", cout, 0);
    check("ign_ovf", ovf, 0);
    repeat (12) @(negedge clk);
    check("ign_pulses", done_cnt - d0, 1);

    // Asynchronous reset mid-shift: outputs clear at once, no done pulse.
    issue(8'h55, 8'h22, 1'b0);
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_sum", sum_out, 0);
    check("arst_cout", cout, 0);
    check("arst_ovf", ovf, 0);
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    d0 = done_cnt;
    @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    check("arst_nodone", done_cnt, d0);
    issue(8'h01, 8'h01, 1'b0);
    wait_done(0, lat);
    check("post_lat", lat, W);
    check("post_sum", sum_out, 8'h02);
    @(negedge clk);

    // The reset-aborted operation is the only accepted start without a done.
    check("done_count", done_cnt, n_start - 1);
    check("busy_in_done", overlap, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
